// File: rtl/pulse_sequencer_if.sv
// Avalon-MM register port of the pulse sequencer.
interface pulse_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pulse_sequencer.sv
// Programmable high/low pulse-train generator with an Avalon-MM register port.
module pulse_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  pulse_sequencer_if.slave   bus,
  output logic               out_port
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     high_time;
  logic [CNT_W-1:0]     low_time;
  logic [PULSE_W-1:0]   pulses;
  logic [CNT_W-1:0]     sh_high;
  logic [CNT_W-1:0]     sh_low;
  logic [PULSE_W-1:0]   sh_pulses;
  logic [CNT_W-1:0]     timer;
  logic [PULSE_W-1:0]   remaining;
  logic                 done;
  logic                 busy;

  logic wr_en;
  logic ctl_wr;
  logic start;
  logic stop;
  logic clr_done;
  logic unused_wdata;

  // A programmed time of 0 behaves as 1 cycle.
  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] x);
    return (x == '0) ? CNT_W'(1) : x;
  endfunction

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign ctl_wr       = wr_en && (bus.address == 2'd0);
  assign start        = ctl_wr & bus.writedata[0];
  assign stop         = ctl_wr & bus.writedata[1];
  assign clr_done     = ctl_wr & bus.writedata[2];
  assign busy         = (state != ST_IDLE);
  assign unused_wdata = ^bus.writedata;

  // Config registers, waveform FSM, timer and pulse counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      high_time <= '0;
      low_time  <= '0;
      pulses    <= '0;
      sh_high   <= '0;
      sh_low    <= '0;
      sh_pulses <= '0;
      timer     <= '0;
      remaining <= '0;
      done      <= 1'b0;
      out_port  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (bus.address)
          2'd1:    high_time <= bus.writedata[CNT_W-1:0];
          2'd2:    low_time  <= bus.writedata[CNT_W-1:0];
          2'd3:    pulses    <= bus.writedata[PULSE_W-1:0];
          default: ;
        endcase
      end

      // Clear first so a same-cycle completion below takes priority.
      if (clr_done) done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state     <= ST_HIGH;
            out_port  <= 1'b1;
            sh_high   <= eff(high_time);
            sh_low    <= eff(low_time);
            sh_pulses <= pulses;
            timer     <= eff(high_time) - CNT_W'(1);
            remaining <= pulses;
            done      <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (stop) begin
            state     <= ST_IDLE;
            out_port  <= 1'b0;
            remaining <= '0;
            timer     <= '0;
          end else if (timer != '0) begin
            timer <= timer - CNT_W'(1);
          end else begin
            state    <= ST_LOW;
            out_port <= 1'b0;
            timer    <= sh_low - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (stop) begin
            state     <= ST_IDLE;
            out_port  <= 1'b0;
            remaining <= '0;
            timer     <= '0;
          end else if (timer != '0) begin
            timer <= timer - CNT_W'(1);
          end else if (sh_pulses == '0) begin
            state    <= ST_HIGH;
            out_port <= 1'b1;
            timer    <= sh_high - CNT_W'(1);
          end else if (remaining == PULSE_W'(1)) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            remaining <= '0;
          end else begin
            state     <= ST_HIGH;
            out_port  <= 1'b1;
            remaining <= remaining - PULSE_W'(1);
            timer     <= sh_high - CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_port <= 1'b0;
        end
      endcase
    end
  end

  // Zero-extended read mux; reads have no side effects.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = {16'(remaining), 13'd0, out_port, done, busy};
      2'd1:    bus.readdata = 32'(high_time);
      2'd2:    bus.readdata = 32'(low_time);
      default: bus.readdata = 32'(pulses);
    endcase
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer against a cycle-indexed waveform model.
module tb_pulse_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic out_port;

  always #5 clk = ~clk;

  pulse_sequencer_if bus_if ();

  pulse_sequencer #(.CNT_W(16), .PULSE_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .out_port (out_port)
  );

  int total = 0;
  int bad   = 0;

  // Software-visible model state.
  logic [15:0] m_hi, m_lo, m_pu;
  logic        m_done;

  // One clock cycle: sample readdata(ra)/out_port, then optionally drive a write.
  task automatic tick(input logic wr, input logic [1:0] wa, input logic [31:0] wd,
                      input logic [1:0] ra, output logic [31:0] rd, output logic o);
    @(negedge clk);
    bus_if.address    = ra;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    #1;
    rd = bus_if.readdata;
    o  = out_port;
    if (wr) begin
      bus_if.address   = wa;
      bus_if.writedata = wd;
      bus_if.write_n   = 1'b0;
    end else begin
      bus_if.chipselect = 1'b0;
    end
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd1: m_hi = d[15:0];
      2'd2: m_lo = d[15:0];
      2'd3: m_pu = d[15:0];
      default: ;
    endcase
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic o;
    tick(1'b1, a, d, 2'd0, rd, o);
    model_write(a, d);
  endtask

  task automatic program_regs(input int hi, input int lo, input int pu);
    wr_reg(2'd1, 32'(hi));
    wr_reg(2'd2, 32'(lo));
    wr_reg(2'd3, 32'(pu));
  endtask

  // START in cycle k=0, optional STOP at k=stop_at, optional extra write at k=wr_cyc.
  task automatic run_wave(input string name, input int stop_at, input int wr_cyc,
                          input logic [1:0] wa, input logic [31:0] wd);
    int eh, el, per, pu, tot, last, j, rem_e;
    logic busy_e, exp_o, done_now, done_e, wr, o;
    logic [1:0] a;
    logic [31:0] d, rd, exp_st;
    eh  = (m_hi == 0) ? 1 : int'(m_hi);
    el  = (m_lo == 0) ? 1 : int'(m_lo);
    per = eh + el;
    pu  = int'(m_pu);
    tot = (pu != 0) ? pu * per : stop_at;
    if (stop_at > 0 && stop_at < tot) tot = stop_at;
    done_e = (stop_at <= 0) && (pu != 0);
    last = tot + 1;
    for (int k = 0; k <= last; k++) begin
      wr = (k == 0) || (k == stop_at) || (k == wr_cyc);
      a  = 2'd0;
      d  = 32'd1;
      if (k == stop_at) d = 32'd2;
      else if (k == wr_cyc && k != 0) begin a = wa; d = wd; end
      tick(wr, a, d, 2'd0, rd, o);
      if (k == wr_cyc && k != 0) model_write(wa, wd);
      if (k >= 1) begin
        j        = k - 1;
        busy_e   = (k <= tot);
        exp_o    = busy_e && ((j % per) < eh);
        rem_e    = (busy_e && pu != 0) ? pu - j / per : 0;
        done_now = !busy_e && done_e;
        exp_st   = {16'(rem_e), 13'd0, exp_o, done_now, busy_e};
        total++;
        if (o !== exp_o) begin
          bad++;
          $display("FAIL %s out_port k=%0d got=%b want=%b", name, k, o, exp_o);
        end
        total++;
        if (rd !== exp_st) begin
          bad++;
          $display("FAIL %s status k=%0d got=%h want=%h", name, k, rd, exp_st);
        end
      end
    end
    m_done = done_e;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic o;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0; m_pu = 0; m_done = 1'b0;
    for (int a = 0; a < 4; a++) begin
      tick(1'b0, 2'd0, 32'd0, 2'(a), rd, o);
      total++;
      if (rd !== 32'd0) begin
        bad++;
        $display("FAIL reset_read addr=%0d got=%h want=0", a, rd);
      end
    end
    total++;
    if (o !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%b want=0", o);
    end
  endtask

  task automatic test_readback(input int hi, input int lo, input int pu);
    logic [31:0] rd;
    logic o;
    logic [31:0] want;
    program_regs(hi, lo, pu);
    for (int a = 1; a < 4; a++) begin
      tick(1'b0, 2'd0, 32'd0, 2'(a), rd, o);
      want = (a == 1) ? 32'(m_hi) : (a == 2) ? 32'(m_lo) : 32'(m_pu);
      total++;
      if (rd !== want) begin
        bad++;
        $display("FAIL readback addr=%0d got=%h want=%h", a, rd, want);
      end
    end
  endtask

  task automatic test_basic;
    test_readback(3, 2, 2);
    run_wave("basic_3_2_2", -1, -1, 2'd0, 32'd0);
  endtask

  task automatic test_zero_times;
    program_regs(0, 0, 4);
    run_wave("zero_times", -1, -1, 2'd0, 32'd0);
  endtask

  task automatic test_clr_done;
    logic [31:0] rd;
    logic o;
    int per;
    program_regs(2, 3, 1);
    per = 5;
    // CLR_DONE lands in the final LOW cycle; the completion must win.
    run_wave("clr_collide", -1, per, 2'd0, 32'd4);
    wr_reg(2'd0, 32'd4);
    tick(1'b0, 2'd0, 32'd0, 2'd0, rd, o);
    total++;
    if (rd[1] !== 1'b0) begin
      bad++;
      $display("FAIL clr_done got=%b want=0", rd[1]);
    end
    m_done = 1'b0;
  endtask

  task automatic test_stop;
    program_regs(5, 5, 0);
    run_wave("stop_cont", 13, -1, 2'd0, 32'd0);
    program_regs(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);
    run_wave("stop_rand", int'($urandom_range(1, 20)), -1, 2'd0, 32'd0);
  endtask

  task automatic test_busy_config;
    program_regs(3, 2, 2);
    run_wave("cfg_hi9", -1, 2, 2'd1, 32'd9);
    program_regs(3, 2, 2);
    run_wave("restart_ign", -1, 4, 2'd0, 32'd1);
    run_wave("after_cfg", -1, -1, 2'd0, 32'd0);
    wr_reg(2'd1, 32'd9);
    run_wave("hi9_run", -1, -1, 2'd0, 32'd0);
  endtask

  task automatic test_start_stop;
    logic [31:0] rd;
    logic o;
    program_regs(2, 2, 3);
    wr_reg(2'd0, 32'd3);
    tick(1'b0, 2'd0, 32'd0, 2'd0, rd, o);
    total++;
    if (rd[0] !== 1'b0 || o !== 1'b0) begin
      bad++;
      $display("FAIL start_stop busy=%b out=%b want=0/0", rd[0], o);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      program_regs(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(1, 4)));
      run_wave("random", -1, -1, 2'd0, 32'd0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic o;
    program_regs(5, 5, 3);
    wr_reg(2'd0, 32'd1);
    tick(1'b0, 2'd0, 32'd0, 2'd0, rd, o);
    tick(1'b0, 2'd0, 32'd0, 2'd0, rd, o);
    total++;
    if (o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre out=%b want=1", o);
    end
    reset = 1'b1;
    tick(1'b0, 2'd0, 32'd0, 2'd0, rd, o);
    reset = 1'b0;
    m_hi = 0; m_lo = 0; m_pu = 0; m_done = 1'b0;
    total++;
    if (o !== 1'b0 || rd !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid out=%b status=%h want=0/0", o, rd);
    end
    tick(1'b0, 2'd0, 32'd0, 2'd1, rd, o);
    total++;
    if (rd !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_hi got=%h want=0", rd);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    test_reset();
    test_basic();
    test_zero_times();
    test_clr_done();
    test_stop();
    test_busy_config();
    test_start_stop();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
